// File: rtl/shared_buf_arbiter_pkg.sv
// shared_buf_pkg: shared sizing helper for the shared buffer arbiter slice
package shared_buf_pkg;
  function automatic int src_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/shared_buf_arbiter_if.sv
// shared_buf_arbiter_if: requester side (req/req_data/gnt) and consumer side (out_valid/out_data/out_src/out_ready) of the merge
interface shared_buf_arbiter_if import shared_buf_pkg::*; #(parameter int NREQ = 2, parameter int WIDTH = 1);
  localparam int SRC_W = src_w(NREQ);
  logic [NREQ-1:0] req;
  logic [NREQ*WIDTH-1:0] req_data;
  logic [NREQ-1:0] gnt;
  logic out_valid;
  logic [WIDTH-1:0] out_data;
  logic [SRC_W-1:0] out_src;
  logic out_ready;
  modport master (output req, req_data, out_ready, input gnt, out_valid, out_data, out_src);
  modport slave (input req, req_data, out_ready, output gnt, out_valid, out_data, out_src);
endinterface

// File: rtl/shared_buf_arbiter_rr_arbiter.sv
// rr_arbiter: round-robin one-hot grant gated by adv_i; ports clk, rst, req_i, adv_i in; gnt_o, idx_o out
module rr_arbiter import shared_buf_pkg::*; #(parameter int NREQ = 2) (
  input  logic clk,
  input  logic rst,
  input  logic [NREQ-1:0] req_i,
  input  logic adv_i,
  output logic [NREQ-1:0] gnt_o,
  output logic [src_w(NREQ)-1:0] idx_o
);
  localparam int SRC_W = src_w(NREQ);
  logic [SRC_W-1:0] ptr_q, ptr_d;
  logic found;
  int j;
  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    found = 1'b0;
    j = 0;
    for (int k = 0; k < NREQ; k++) begin
      j = (int'(ptr_q) + k) % NREQ;
      if (!found && !rst && adv_i && req_i[j]) begin
        found = 1'b1;
        gnt_o[j] = 1'b1;
        idx_o = SRC_W'(j);
      end
    end
    ptr_d = found ? ((idx_o == SRC_W'(NREQ-1)) ? '0 : idx_o + 1'b1) : ptr_q;
  end
  always_ff @(posedge clk) begin
    if (rst) ptr_q <= '0;
    else ptr_q <= ptr_d;
  end
endmodule

// File: rtl/shared_buf_arbiter.sv
// shared_buf_arbiter: round-robin merge of NREQ requesters into a DEPTH-stage valid/ready chain; ports clk, rst, bus (slave: req/req_data in, gnt out, out_valid/out_data/out_src out, out_ready in)
module shared_buf_arbiter import shared_buf_pkg::*; #(
  parameter int NREQ = 2,
  parameter int WIDTH = 1,
  parameter int DEPTH = 2
) (
  input logic clk,
  input logic rst,
  shared_buf_arbiter_if.slave bus
);
  localparam int SRC_W = src_w(NREQ);
  typedef struct packed {
    logic valid;
    logic [SRC_W-1:0] src;
    logic [WIDTH-1:0] data;
  } stage_t;
  logic [NREQ-1:0] gnt;
  logic [SRC_W-1:0] idx;
  logic adv0;
  stage_t in_s;
  rr_arbiter #(.NREQ(NREQ)) u_arb (
    .clk(clk),
    .rst(rst),
    .req_i(bus.req),
    .adv_i(adv0),
    .gnt_o(gnt),
    .idx_o(idx)
  );
  assign bus.gnt = gnt;
  assign in_s = (|gnt) ? stage_t'{valid: 1'b1, src: idx, data: bus.req_data[int'(idx)*WIDTH +: WIDTH]} : '0;
  for (genvar k = 0; k < DEPTH; k++) begin : g
    stage_t q_q, prev;
    logic adv;
    if (k == DEPTH-1) begin : g_last
      assign adv = !q_q.valid || bus.out_ready;
    end else begin : g_mid
      assign adv = !q_q.valid || g[k+1].adv;
    end
    if (k == 0) begin : g_head
      assign prev = in_s;
    end else begin : g_tail
      assign prev = g[k-1].q_q;
    end
    always_ff @(posedge clk) begin
      if (rst) q_q <= '0;
      else if (adv) q_q <= prev;
    end
  end
  assign adv0 = g[0].adv;
  assign bus.out_valid = g[DEPTH-1].q_q.valid;
  assign bus.out_data = g[DEPTH-1].q_q.data;
  assign bus.out_src = g[DEPTH-1].q_q.src;
endmodule

// File: tb/tb_shared_buf_arbiter.sv
// tb_shared_buf_arbiter: directed checks of reset, single source, contention, back-pressure, bubble collapse and mid-run reset
module tb_shared_buf_arbiter;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int total = 0;
  int fails = 0;
  shared_buf_arbiter_if #(.NREQ(2), .WIDTH(1)) bus ();
  shared_buf_arbiter #(.NREQ(2), .WIDTH(1), .DEPTH(2)) dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  task automatic step(input logic r, input logic [1:0] q, input logic [1:0] d, input logic rdy);
    @(negedge clk);
    rst = r;
    bus.req = q;
    bus.req_data = d;
    bus.out_ready = rdy;
    #1;
  endtask
  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic out(input string tag, input logic v, input logic s, input logic d);
    chk({tag, "_valid"}, 8'(bus.out_valid), 8'(v));
    if (v) begin
      chk({tag, "_src"}, 8'(bus.out_src), 8'(s));
      chk({tag, "_data"}, 8'(bus.out_data), 8'(d));
    end
  endtask
  initial begin
    bus.req = 2'b11;
    bus.req_data = 2'b00;
    bus.out_ready = 1'b1;
    step(1, 2'b11, 2'b00, 1);
    chk("rst0_gnt", 8'(bus.gnt), 8'h0);
    chk("rst0_valid", 8'(bus.out_valid), 8'h0);
    chk("rst0_data", 8'(bus.out_data), 8'h0);
    chk("rst0_src", 8'(bus.out_src), 8'h0);
    step(1, 2'b11, 2'b00, 1);
    chk("rst1_gnt", 8'(bus.gnt), 8'h0);
    chk("rst1_valid", 8'(bus.out_valid), 8'h0);
    step(0, 2'b11, 2'b01, 1);
    chk("cont0_gnt", 8'(bus.gnt), 8'h1);
    chk("cont0_valid", 8'(bus.out_valid), 8'h0);
    step(0, 2'b11, 2'b10, 1);
    chk("cont1_gnt", 8'(bus.gnt), 8'h2);
    chk("cont1_valid", 8'(bus.out_valid), 8'h0);
    step(0, 2'b11, 2'b00, 1);
    chk("cont2_gnt", 8'(bus.gnt), 8'h1);
    out("cont2", 1, 0, 1);
    step(0, 2'b11, 2'b00, 1);
    chk("cont3_gnt", 8'(bus.gnt), 8'h2);
    out("cont3", 1, 1, 1);
    step(0, 2'b00, 2'b00, 1);
    chk("cont4_gnt", 8'(bus.gnt), 8'h0);
    out("cont4", 1, 0, 0);
    step(0, 2'b00, 2'b00, 1);
    out("cont5", 1, 1, 0);
    step(0, 2'b00, 2'b00, 1);
    out("drain", 0, 0, 0);
    step(0, 2'b01, 2'b01, 1);
    chk("single0_gnt", 8'(bus.gnt), 8'h1);
    out("single0", 0, 0, 0);
    step(0, 2'b01, 2'b00, 1);
    chk("single1_gnt", 8'(bus.gnt), 8'h1);
    out("single1", 0, 0, 0);
    step(0, 2'b01, 2'b01, 1);
    chk("single2_gnt", 8'(bus.gnt), 8'h1);
    out("single2", 1, 0, 1);
    step(0, 2'b00, 2'b00, 1);
    chk("single3_gnt", 8'(bus.gnt), 8'h0);
    out("single3", 1, 0, 0);
    step(0, 2'b10, 2'b10, 0);
    chk("bubble_gnt", 8'(bus.gnt), 8'h2);
    out("bubble", 1, 0, 1);
    for (int i = 0; i < 4; i++) begin
      step(0, 2'b11, 2'b00, 0);
      chk("stall_gnt", 8'(bus.gnt), 8'h0);
      out("stall", 1, 0, 1);
    end
    step(0, 2'b11, 2'b00, 1);
    chk("release0_gnt", 8'(bus.gnt), 8'h1);
    out("release0", 1, 0, 1);
    step(0, 2'b00, 2'b00, 1);
    chk("release1_gnt", 8'(bus.gnt), 8'h0);
    out("release1", 1, 1, 1);
    step(0, 2'b00, 2'b00, 1);
    out("release2", 1, 0, 0);
    step(0, 2'b00, 2'b00, 1);
    out("release3", 0, 0, 0);
    step(0, 2'b11, 2'b11, 0);
    chk("fill0_gnt", 8'(bus.gnt), 8'h2);
    step(0, 2'b11, 2'b11, 0);
    chk("fill1_gnt", 8'(bus.gnt), 8'h1);
    step(0, 2'b11, 2'b11, 0);
    chk("full_gnt", 8'(bus.gnt), 8'h0);
    out("full", 1, 1, 1);
    step(1, 2'b11, 2'b11, 0);
    chk("midrst_gnt", 8'(bus.gnt), 8'h0);
    step(0, 2'b11, 2'b00, 1);
    chk("post_rst_gnt", 8'(bus.gnt), 8'h1);
    out("post_rst0", 0, 0, 0);
    step(0, 2'b00, 2'b00, 1);
    out("post_rst1", 0, 0, 0);
    step(0, 2'b00, 2'b00, 1);
    out("post_rst2", 1, 0, 0);
    step(0, 2'b00, 2'b00, 1);
    out("post_rst3", 0, 0, 0);
    $display("%0d/%0d checks passed", total - fails, total);
    $finish;
  end
endmodule
